// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode-side hazard request and forwarding/stall response bundle
interface hazard_scoreboard_if #(
    parameter int DEPTH = 3,
    parameter int CNT_W = 32
);
    localparam int SW = $clog2(DEPTH + 1);
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [4:0]       id_rd;
    logic             id_reg_wr;
    logic             id_is_load;
    logic             br_taken;
    logic             trap_flush;
    logic             pipe_hold;
    logic             stall;
    logic             flush;
    logic [SW-1:0]    fwd_sel_a;
    logic [SW-1:0]    fwd_sel_b;
    logic [DEPTH-1:0] stage_valid;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_reg_wr, id_is_load,
               br_taken, trap_flush, pipe_hold,
        input  stall, flush, fwd_sel_a, fwd_sel_b, stage_valid, stall_cycles
    );
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_reg_wr, id_is_load,
               br_taken, trap_flush, pipe_hold,
        output stall, flush, fwd_sel_a, fwd_sel_b, stage_valid, stall_cycles
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight write tracking, operand forwarding select and stall/flush for a DEPTH-stage pipeline
module hazard_scoreboard #(
    parameter int DEPTH      = 3,
    parameter int ALU_STAGE  = 1,
    parameter int LOAD_STAGE = 2,
    parameter int BR_STAGE   = 1,
    parameter int CNT_W      = 32
) (
    input logic clk,
    input logic rst,
    hazard_scoreboard_if.slave bus
);
    localparam int SW = $clog2(DEPTH + 1);
    logic [DEPTH-1:0]      v, wr, ld, keep, avail;
    logic [DEPTH-1:0][4:0] rd;
    logic [SW-1:0]         sel_a, sel_b;
    logic                  haz_a, haz_b, redirect, stall, issue;
    logic [CNT_W-1:0]      cnt;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            avail[i] = (i + 1) >= (ld[i] ? LOAD_STAGE : ALU_STAGE);
            keep[i]  = bus.trap_flush ? (i == DEPTH - 1) : (!bus.br_taken || (i + 1) >= BR_STAGE);
        end
    end

    // Scan oldest to youngest so a younger match always overwrites an older one
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        haz_a = 1'b0;
        haz_b = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (v[i] && wr[i] && bus.id_rs1_used && bus.id_rs1 != 5'd0 && rd[i] == bus.id_rs1) begin
                sel_a = avail[i] ? SW'(i + 1) : '0;
                haz_a = !avail[i];
            end
            if (v[i] && wr[i] && bus.id_rs2_used && bus.id_rs2 != 5'd0 && rd[i] == bus.id_rs2) begin
                sel_b = avail[i] ? SW'(i + 1) : '0;
                haz_b = !avail[i];
            end
        end
    end

    assign redirect         = bus.br_taken || bus.trap_flush;
    assign stall            = !rst && bus.id_valid && (haz_a || haz_b) && !redirect;
    assign issue            = bus.id_valid && !stall && !redirect && !bus.pipe_hold;
    assign bus.stall        = stall;
    assign bus.flush        = !rst && redirect;
    assign bus.fwd_sel_a    = rst ? '0 : sel_a;
    assign bus.fwd_sel_b    = rst ? '0 : sel_b;
    assign bus.stage_valid  = rst ? '0 : v;
    assign bus.stall_cycles = cnt;

    // x0 destinations enter with wr cleared so they can never match
    always_ff @(posedge clk) begin
        if (rst) begin
            v   <= '0;
            cnt <= '0;
        end else begin
            if (bus.pipe_hold) begin
                v <= v & keep;
            end else begin
                v  <= {v[DEPTH-2:0] & keep[DEPTH-2:0], issue};
                wr <= {wr[DEPTH-2:0], bus.id_reg_wr && bus.id_rd != 5'd0};
                ld <= {ld[DEPTH-2:0], bus.id_is_load};
                rd <= {rd[DEPTH-2:0], bus.id_rd};
            end
            if (stall && cnt != '1) cnt <= cnt + CNT_W'(1);
        end
    end
endmodule
